// File: rtl/shift_reg_universal.sv
// -----------------------------------------------------------------------------
// shift_reg_universal
//
// Parametrised universal shift register with an autonomous burst engine,
// used as the serial/parallel converter in the peripheral datapath.
//
// In IDLE the register follows a per-cycle mode (hold / shift right /
// shift left / parallel load) qualified by enable. A start pulse with a
// valid burst_len (1..WIDTH) moves the block into BURST, where it shifts
// one bit per clock in the latched direction until the count expires,
// then pulses done for one cycle. Mode, enable and start are ignored
// while busy.
//
// Optional build macro: SHIFTREG_ROTATE_EN
//   Adds input 'rotate'. When high, the serial input of a shift is taken
//   from the bit leaving the opposite end (rotate instead of shift), for
//   both mode-driven and burst shifts. Without the macro the port is
//   absent and shifts always use shift_in_msb / shift_in_lsb.
//
// Parameters:
//   WIDTH  register width in bits (>= 2)
//   LEN_W  width of burst_len; 2**LEN_W must exceed WIDTH
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   enable         qualifies mode in IDLE (0 = hold)
//   mode           00 hold, 01 shift right, 10 shift left, 11 load
//   load_data      parallel load value
//   shift_in_msb   serial in, enters bit WIDTH-1 on right shift
//   shift_in_lsb   serial in, enters bit 0 on left shift
//   start          burst request pulse
//   burst_dir      0 = right, 1 = left (sampled with start)
//   burst_len      number of bits to shift in the burst
//   rotate         (SHIFTREG_ROTATE_EN only) rotate instead of shift
//   parallel_out   register contents
//   shift_out_lsb  parallel_out[0]
//   shift_out_msb  parallel_out[WIDTH-1]
//   busy           burst in progress
//   done           one-cycle pulse after the last burst shift
// -----------------------------------------------------------------------------
module shift_reg_universal #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_in_msb,
  input  logic             shift_in_lsb,
  input  logic             start,
  input  logic             burst_dir,
  input  logic [LEN_W-1:0] burst_len,
`ifdef SHIFTREG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] parallel_out,
  output logic             shift_out_lsb,
  output logic             shift_out_msb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             dir_reg, dir_next;
  logic             done_reg, done_next;

  logic             rotate_sel;
  logic             right_in;
  logic             left_in;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  logic             len_ok;

`ifdef SHIFTREG_ROTATE_EN
  assign rotate_sel = rotate;
`else
  assign rotate_sel = 1'b0;
`endif

  // In rotate mode the bit falling off one end re-enters at the other.
  assign right_in = rotate_sel ? data_reg[0]       : shift_in_msb;
  assign left_in  = rotate_sel ? data_reg[WIDTH-1] : shift_in_lsb;

  // Both shifted candidates are always available; the FSM just picks one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shr_vec[gi]   = data_reg[gi+1];
      assign shl_vec[gi+1] = data_reg[gi];
    end
  endgenerate
  assign shr_vec[WIDTH-1] = right_in;
  assign shl_vec[0]       = left_in;

  // A start with an out-of-range length is not a burst request at all;
  // the normal mode path handles that cycle instead.
  assign len_ok = (burst_len != '0) && (burst_len <= WIDTH_L);

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && len_ok) begin
          // Accept edge: latch the request only, no shift yet.
          state_next = BURST;
          cnt_next   = burst_len;
          dir_next   = burst_dir;
        end else if (enable) begin
          case (mode)
            2'b01:   data_next = shr_vec;
            2'b10:   data_next = shl_vec;
            2'b11:   data_next = load_data;
            default: data_next = data_reg;
          endcase
        end
      end
      BURST: begin
        data_next = dir_reg ? shl_vec : shr_vec;
        cnt_next  = cnt_reg - ONE_L;
        if (cnt_reg == ONE_L) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      done_reg  <= done_next;
    end
  end

  assign parallel_out  = data_reg;
  assign shift_out_lsb = data_reg[0];
  assign shift_out_msb = data_reg[WIDTH-1];
  assign busy          = (state_reg == BURST);
  assign done          = done_reg;

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised successor to the fixed 4-bit serial shift register.
- Configurable width; per-cycle mode select (hold / shift right / shift left / parallel load); serial in and out at both ends; full parallel readout.
- Adds a burst engine: one start pulse shifts N bits autonomously, with busy/done handshake.
- Serial/parallel converter for the peripheral datapath.

Parameters:
WIDTH, 8, register width in bits (>= 2)
LEN_W, 4, width of burst_len; must satisfy 2**LEN_W > WIDTH

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  qualifies mode in IDLE; 0 = hold
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
load_data  input  WIDTH  parallel load value
shift_in_msb  input  1  serial in, enters bit WIDTH-1 on right shift
shift_in_lsb  input  1  serial in, enters bit 0 on left shift
start  input  1  burst request, single-cycle pulse
burst_dir  input  1  0 = right, 1 = left; sampled with start
burst_len  input  LEN_W  bits to shift in the burst (1..WIDTH)
parallel_out  output  WIDTH  register contents
shift_out_lsb  output  1  = parallel_out[0]
shift_out_msb  output  1  = parallel_out[WIDTH-1]
busy  output  1  burst in progress
done  output  1  one-cycle pulse after the last burst shift

Behaviour:
- Clock is the only clock. Reset is asynchronous and active-low. Reset is named reset_n.
- On reset_n=0, immediately and regardless of clock:
  - register = 0; busy = 0; done = 0; burst counter = 0; FSM = IDLE.
  - Applies mid-burst as well: the burst is aborted and no done pulse is issued.
- Shift rules:
  - Right shift: reg <= {shift_in_msb, reg[WIDTH-1:1]}.
  - Left shift: reg <= {reg[WIDTH-2:0], shift_in_lsb}.
  - Load: reg <= load_data.
- shift_out_* and parallel_out are combinational from the register, so the new value is visible directly after the edge.
- FSM states: IDLE, BURST.
- IDLE:
  - start=1 and burst_len in 1..WIDTH:
    - Latch burst_dir and burst_len into the counter.
    - Go to BURST with busy=1.
    - No shift on this edge; start has priority over mode/enable.
  - start=1 and burst_len=0 or > WIDTH: ignored. The normal mode/enable action applies instead.
  - Otherwise, if enable=1, apply mode. If enable=0, hold.
- BURST:
  - Each edge shifts one bit in the latched direction, using the live shift_in_* value, and decrements the counter.
  - On the edge where the counter reaches 0, go to IDLE: busy=0 and done=1 for exactly one cycle.
  - enable, mode and start are ignored while busy=1. A start arriving then is dropped, not queued.
- Burst latency:
  - start sampled at edge k; shifts occur at edges k+1 .. k+N.
  - busy is high from after edge k to after edge k+N. done is high between edges k+N and k+N+1.
- Back-to-back bursts: a start may be sampled in the cycle where done=1, since the FSM is already IDLE. The new burst begins normally.
- Outputs change only on clock edges or on reset_n.

Optional Feature:
- Macro: SHIFTREG_ROTATE_EN.
- When defined:
  - An extra input port rotate (1 bit) exists.
  - When rotate=1, the serial input is replaced by the bit shifted out of the opposite end:
    - right: reg <= {reg[0], reg[WIDTH-1:1]}
    - left: reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}
  - This applies to both mode-driven shifts and bursts. rotate is sampled every shift edge.
- When undefined:
  - The port is absent and behaviour is identical to rotate=0.

Test Plan:
- Reset: drive reset_n=0 mid-cycle with reg=8'hA5 -> parallel_out=0, busy=0, done=0 without waiting for a clock edge. Also drive reset_n=0 during a burst -> no done pulse after release.
- Load and shift right: mode=11, load_data=8'hB4, then mode=01 with shift_in_msb=1 for 2 cycles -> 8'hED. shift_out_lsb follows bit 0: 0, 0, 1.
- Shift left and hold: load 8'h81; mode=10, shift_in_lsb=0 for 1 cycle -> 8'h02; enable=0 for 3 cycles -> stays 8'h02.
- Burst: load 8'hF0; start, burst_dir=0, burst_len=4, shift_in_msb=0 -> busy high 4 cycles, reg=8'h0F, done high exactly 1 cycle. mode=11 toggled during the burst has no effect.
- Boundaries:
  - burst_len=0 with start -> no busy.
  - burst_len=9 -> ignored.
  - burst_len=8 left with shift_in_lsb=1 from 8'h00 -> 8'hFF.
  - start during busy -> dropped.
  - start in the done cycle -> second burst runs.
- SHIFTREG_ROTATE_EN build: load 8'h81, rotate=1, burst right len=1 -> 8'hC0. burst left len=8 -> 8'hC0 (unchanged after a full rotation).
